// File: rtl/exp_lane_array.sv
// exp_lane_array: multi-lane piecewise-linear exp(x) for softmax with valid/ready, lane masking and row sum.
// Optional EXP_SAT_STATUS_EN adds out_status with per-lane clamp flags.
module exp_lane_array #(
    parameter int LANES     = 4,
    parameter int SUM_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_data,
    input  logic [LANES-1:0]      in_mask,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   out_data,
    output logic                  out_last,
    output logic [SUM_WIDTH-1:0]  out_sum
`ifdef EXP_SAT_STATUS_EN
    ,
    output logic [2*LANES-1:0]    out_status
`endif
);
    localparam int LW = 16 + $clog2(LANES);
    localparam int F  = 48;
    typedef logic [128:0][15:0] rom_t;

    // Table built at elaboration: exp(-1/16) by Taylor series, then repeated products in Q.48
    function automatic rom_t make_base();
        logic [127:0] r, t, v;
        rom_t b;
        r = 128'd1 << F;
        t = r;
        for (int n = 1; n < 24; n++) begin
            t = t / 128'(16 * n);
            r = (n % 2 == 1) ? r - t : r + t;
        end
        v = 128'd1 << F;
        for (int k = 0; k <= 128; k++) begin
            b[k] = 16'((v + (128'd1 << (F - 16))) >> (F - 15));
            v = (v * r) >> F;
        end
        return b;
    endfunction

    localparam rom_t BASE = make_base();

    logic                 adv;
    logic                 v1, v2, l1, l2, prev_last;
    logic [6:0]           idx1  [LANES];
    logic [7:0]           frac1 [LANES];
    logic [7:0]           frac2 [LANES];
    logic [15:0]          b2    [LANES];
    logic [15:0]          s2    [LANES];
    logic [LANES-1:0]     z1, o1, z2, o2, pos, und;
    logic [14:0]          neg   [LANES];
    logic [15:0]          y     [LANES];
    logic [LW-1:0]        lane_sum;
    logic [SUM_WIDTH-1:0] base_acc, nxt_acc;
    logic [SUM_WIDTH:0]   sum_ext;
`ifdef EXP_SAT_STATUS_EN
    logic [2*LANES-1:0]   st1, st2;
`endif

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    always_comb begin
        pos = '0;
        und = '0;
        for (int i = 0; i < LANES; i++) begin
            neg[i] = -in_data[16*i +: 15];
            pos[i] = ~in_data[16*i+15] & |in_data[16*i +: 15];
            und[i] = in_data[16*i +: 16] == 16'h8000;
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            y[i] = z2[i] ? 16'd0 : o2[i] ? 16'h8000 :
                   b2[i] - 16'(({8'd0, s2[i]} * {16'd0, frac2[i]} + 24'd128) >> 8);
            lane_sum = lane_sum + LW'(y[i]);
        end
        base_acc = prev_last ? '0 : out_sum;
        sum_ext  = {1'b0, base_acc} + (SUM_WIDTH + 1)'(lane_sum);
        nxt_acc  = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            out_last  <= 1'b0;
            prev_last <= 1'b1;
            out_sum   <= '0;
            out_data  <= '0;
            z1        <= '0;
            o1        <= '0;
            z2        <= '0;
            o2        <= '0;
            for (int i = 0; i < LANES; i++) begin
                idx1[i]  <= '0;
                frac1[i] <= '0;
                frac2[i] <= '0;
                b2[i]    <= '0;
                s2[i]    <= '0;
            end
`ifdef EXP_SAT_STATUS_EN
            st1        <= '0;
            st2        <= '0;
            out_status <= '0;
`endif
        end else if (adv) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (in_valid) begin
                l1 <= in_last;
                for (int i = 0; i < LANES; i++) begin
                    idx1[i]  <= neg[i][14:8];
                    frac1[i] <= neg[i][7:0];
                    z1[i]    <= ~in_mask[i] | und[i];
                    o1[i]    <= in_mask[i] & pos[i];
`ifdef EXP_SAT_STATUS_EN
                    st1[2*i]   <= in_mask[i] & pos[i];
                    st1[2*i+1] <= in_mask[i] & und[i];
`endif
                end
            end
            if (v1) begin
                l2 <= l1;
                z2 <= z1;
                o2 <= o1;
                for (int i = 0; i < LANES; i++) begin
                    b2[i]    <= BASE[8'(idx1[i])];
                    s2[i]    <= BASE[8'(idx1[i])] - BASE[8'(idx1[i]) + 8'd1];
                    frac2[i] <= frac1[i];
                end
`ifdef EXP_SAT_STATUS_EN
                st2 <= st1;
`endif
            end
            if (v2) begin
                out_last  <= l2;
                out_sum   <= nxt_acc;
                prev_last <= l2;
                for (int i = 0; i < LANES; i++)
                    out_data[16*i +: 16] <= y[i];
`ifdef EXP_SAT_STATUS_EN
                out_status <= st2;
`endif
            end
        end
    end
endmodule

// File: tb/tb_exp_lane_array.sv
// tb_exp_lane_array: directed vectors plus backpressure and mid-row reset sequences for exp_lane_array.
module tb_exp_lane_array;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last;
    logic [63:0] in_data, out_data;
    logic [3:0]  in_mask;
    logic [31:0] out_sum;
    int          total = 0;
    int          bad = 0;
`ifdef EXP_SAT_STATUS_EN
    logic [7:0]  out_status;
`endif

    exp_lane_array #(.LANES(4), .SUM_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mask(in_mask), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_sum(out_sum)
`ifdef EXP_SAT_STATUS_EN
        , .out_status(out_status)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic [3:0]  m;
        logic        l;
        logic [63:0] y;
        logic [31:0] s;
        logic [7:0]  st;
    } vec_t;

    vec_t        tv[7];
    logic [63:0] sd[4];
    logic [63:0] sy[4];
    logic [31:0] ss[4];
    logic [63:0] rx_d[4];
    logic [31:0] rx_s[4];
    logic [63:0] held;
    logic        held_v;
    int          n, k, got;

    initial begin
        tv[0] = '{64'h0000_0000_0000_0000, 4'hF, 1'b1, 64'h8000_8000_8000_8000, 32'd131072, 8'h00};
        tv[1] = '{64'h8000_FF80_F800_F000, 4'hF, 1'b1, 64'h0000_7C1F_4DA3_2F17, 32'd63705,  8'h80};
        tv[2] = '{64'h8000_8000_8000_0400, 4'h1, 1'b1, 64'h0000_0000_0000_8000, 32'd32768,  8'h01};
        tv[3] = '{64'h0001_F000_7FFF_FFFF, 4'hB, 1'b1, 64'h8000_0000_8000_7FF8, 32'd98296,  8'h44};
        tv[4] = '{64'h0000_0000_0000_0000, 4'hF, 1'b0, 64'h8000_8000_8000_8000, 32'd131072, 8'h00};
        tv[5] = '{64'h0000_0000_0000_0000, 4'hF, 1'b1, 64'h8000_8000_8000_8000, 32'd262144, 8'h00};
        tv[6] = '{64'h0000_0000_0000_0000, 4'hF, 1'b1, 64'h8000_8000_8000_8000, 32'd131072, 8'h00};
        sd = '{64'h0000_0000_0000_0000, 64'hF000_F000_F000_F000, 64'hF800_F800_F800_F800, 64'hFF80_FF80_FF80_FF80};
        sy = '{64'h8000_8000_8000_8000, 64'h2F17_2F17_2F17_2F17, 64'h4DA3_4DA3_4DA3_4DA3, 64'h7C1F_7C1F_7C1F_7C1F};
        ss = '{32'd131072, 32'd48220, 32'd79500, 32'd127100};
        in_valid = 1'b0; in_data = '0; in_mask = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            in_data = tv[i].d; in_mask = tv[i].m; in_last = tv[i].l; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 0;
            while (!out_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            if (i == 0) chk("latency", 64'(n), 64'd2);
            chk($sformatf("v%0d_data", i), out_data, tv[i].y);
            chk($sformatf("v%0d_sum", i), 64'(out_sum), 64'(tv[i].s));
            chk($sformatf("v%0d_last", i), 64'(out_last), 64'(tv[i].l));
`ifdef EXP_SAT_STATUS_EN
            chk($sformatf("v%0d_status", i), 64'(out_status), 64'(tv[i].st));
`endif
            @(posedge clk); #1;
        end

        k = 0; got = 0; held_v = 1'b0; held = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            out_ready = (c >= 5);
            in_valid = (k < 4);
            in_data = sd[k < 4 ? k : 0]; in_mask = 4'hF; in_last = 1'b1;
            #1;
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", out_data, held);
            end
            if (c == 4) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_accepted", 64'(k), 64'd3);
            end
            held_v = out_valid & ~out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
                rx_d[got] = out_data;
                rx_s[got] = out_sum;
                got++;
            end
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'd4);
        for (int j = 0; j < got; j++) begin
            chk($sformatf("stream%0d_data", j), rx_d[j], sy[j]);
            chk($sformatf("stream%0d_sum", j), 64'(rx_s[j]), 64'(ss[j]));
        end
        repeat (4) @(posedge clk);
        #1;

        in_data = 64'hF000_F000_F000_F000; in_mask = 4'hF; in_last = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(out_sum), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        in_data = '0; in_mask = 4'hF; in_last = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("post_reset_valid", 64'(out_valid), 64'd1);
        chk("post_reset_sum", 64'(out_sum), 64'd131072);
        chk("post_reset_last", 64'(out_last), 64'd1);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("post_reset_no_stale", 64'(n), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exp_lane_array.md
Name: exp_lane_array

Overview:
- Parametrised multi-lane fixed-point exponent unit for the softmax stage of the attention layer.
- Each lane computes exp(x) for a score x that has already had the row maximum subtracted.
- The approximation is piecewise-linear over a ROM.
- The block adds valid/ready flow control, per-lane masking for padded words, and a running per-row sum of outputs that feeds the softmax denominator.

Parameters:
- LANES, 4, number of parallel exponent lanes (1..16).
- SUM_WIDTH, 32, width of the row accumulator; the accumulator saturates at its maximum.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  16*LANES  lane i at [16i+15:16i]; signed Q4.12.
- in_mask  in  LANES  1 = lane active; 0 = padded lane.
- in_last  in  1  beat is the final beat of a row.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  16*LANES  unsigned Q1.15; 0x8000 = 1.0.
- out_last  out  1  in_last delayed with its beat.
- out_sum  out  SUM_WIDTH  row sum including the current beat; meaningful when out_last=1.

Behaviour:
- Reset: all stage valids 0, data registers 0, accumulator 0, "previous beat was last" flag 1. Outputs: out_valid=0, out_data=0, out_last=0, out_sum=0.
- Reset asserted mid-row discards all in-flight beats and the partial sum.
- Pipeline has 3 register stages:
  - S1: magnitude m = -x (16 bit), clamp, mask.
  - S2: ROM read of base and slope.
  - S3: interpolation, lane sum, accumulate.
- Stalling:
  - advance = out_ready | ~S3.valid.
  - in_ready = advance.
  - All stages shift together on advance and hold otherwise; data and valids are frozen under stall.
  - Latency is exactly 3 cycles from the in_valid&in_ready edge to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Per-lane arithmetic:
  - idx = m[14:8] (7 bit), frac = m[7:0].
  - base[k] = round(32768*exp(-k/16)) for k=0..128.
  - slope[k] = base[k] - base[k+1] for k=0..127.
  - y = base[idx] - ((slope[idx]*frac + 128) >> 8), 16-bit unsigned.
- Clamps:
  - x > 0 (sign 0, nonzero): y = 0x8000.
  - x = 0x8000 (-8.0, m not representable): y = 0.
  - Masked lane: y = 0.
- Lane sum and accumulation:
  - Lane sum = sum of the LANES y values; width 16+clog2(LANES).
  - When a beat loads into S3: acc = (prev_last ? 0 : acc) + lane_sum, saturating at 2^SUM_WIDTH-1. prev_last is then set to that beat's last.
  - out_sum = acc.
- Consecutive rows need no idle cycle between them.
- in_valid=0 inserts bubbles; bubbles do not touch acc or prev_last.
- in_data, in_mask and in_last are sampled only on in_valid&in_ready.

Optional Feature:
- Macro: EXP_SAT_STATUS_EN.
- Defined:
  - Extra port out_status, out, 2*LANES.
  - Lane i bit [2i] = positive-input clamp; bit [2i+1] = -8.0 underflow clamp.
  - Pipelined with out_data and held under stall; reset 0.
  - Masked lanes report 0.
- Undefined: port absent, no status logic, behaviour otherwise identical.

Test Plan:
- LANES=4, all lanes x=0x0000, mask=4'hF, last=1 -> after 3 cycles every lane 0x8000, out_sum=131072, out_last=1.
- Lane values x=0xF000 / 0xF800 / 0xFF80 / 0x8000 -> 0x2F17 / 0x4DA3 / 0x7C1F / 0x0000.
  - With EXP_SAT_STATUS_EN: status bit [7]=1, all others 0.
- x=0x0400 (positive) on lane 0 with mask=4'b0001 -> lane0 0x8000, lanes 1-3 0, out_sum=32768.
- Two beats of all-zero input, last=0 then 1, then a third beat last=1 -> out_sum 131072, 262144, then 131072 (accumulator restarts).
- Hold out_ready=0 for 5 cycles while streaming 4 beats -> in_ready low after the pipeline fills. No beat is lost or duplicated, and out_data is stable while out_valid&~out_ready.
- Assert reset for 1 cycle mid-row (2 beats in flight) -> out_valid=0 immediately. The next row's out_sum excludes the pre-reset beats.
